// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic controller.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_bit_cell.sv
// 1-bit full adder built from a 1-to-8 decode of {a, b, cin}; sum and carry
// are ORs of the minterms where each is true.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic [7:0] dec;

    // One-hot decode of the three input bits
    always_comb begin
        dec = 8'b0;
        dec[{a, b, cin}] = 1'b1;
    end

    assign sum  = dec[1] | dec[2] | dec[4] | dec[7];
    assign cout = dec[3] | dec[5] | dec[6] | dec[7];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, one bit per clock,
// LSB first, framed by a start/busy/done handshake.
module serial_addsub_ctrl
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    // Partial sum holds only the upper WIDTH-1 bits; the newest bit enters at the top
    logic [WIDTH-2:0] shs_q, shs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sum_bit;
    logic             cell_cout;
    logic [WIDTH-1:0] sum_cat;

    fa_bit_cell u_fa (
        .a    (sha_q[0]),
        .b    (shb_q[0]),
        .cin  (carry_q),
        .sum  (sum_bit),
        .cout (cell_cout)
    );

    assign sum_cat = {sum_bit, shs_q};

    // Next-state and datapath updates; everything holds unless a step says otherwise
    always_comb begin
        state_d  = state_q;
        sha_d    = sha_q;
        shb_d    = shb_q;
        shs_d    = shs_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    // Subtract as a + ~b + 1: the +1 comes in as the initial carry
                    shb_d   = (mode == MODE_SUB) ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shs_d   = sum_cat[WIDTH-1:1];
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                carry_d = cell_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    result_d = sum_cat;
                    cout_d   = cell_cout;
                    // Signed overflow: carry into MSB differs from carry out of MSB
                    ovf_d    = carry_q ^ cell_cout;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sha_q    <= '0;
            shb_q    <= '0;
            shs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            shs_q    <= shs_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: vector table, scoreboard queue
// popped on done, and hand-written sequences for the multi-cycle corners.
module tb_serial_addsub_ctrl;

    localparam int unsigned W = 8;

    typedef logic [W+1:0] exp_t;  // {result, cout, ovf}

    typedef struct {
        logic         m;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t hold_exp = '0;

    serial_addsub_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: wide arithmetic plus sign-rule overflow
    function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] yy;
        logic         o;
        yy = m ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, m};
        o  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
        return {s[W-1:0], s[W], o};
    endfunction

    // Monitor: reset clears outputs, done pops the scoreboard, otherwise outputs hold
    always @(negedge clk) begin
        if (rst) begin
            hold_exp = '0;
            check("reset_outputs", 64'({busy, done, result, cout, ovf}), 64'(0));
        end else if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                hold_exp = sb.pop_front();
                check("done_result", 64'({result, cout, ovf}), 64'(hold_exp));
            end
        end else begin
            check("outputs_hold", 64'({result, cout, ovf}), 64'(hold_exp));
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // One full operation with latency and busy-length checks
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e);
        int  n;
        int  bc;
        bit  got;
        wait_idle();
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs after launch; they must not matter
        a     = W'($urandom);
        b     = W'($urandom);
        mode  = ~m;
        bc    = busy ? 1 : 0;
        n     = 0;
        got   = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (busy) bc++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 64'(got), 64'(1));
        end else begin
            check("done_latency", 64'(n), 64'(W));
            check("busy_cycles", 64'(bc), 64'(W + 1));
            @(posedge clk);
            #1;
            check("idle_after_done", 64'({busy, done}), 64'(0));
        end
    endtask

    vec_t tbl[10];
    int   idx[$];
    int   d0;
    int   k;

    initial begin
        tbl[0] = '{1'b0, 8'd100, 8'd27,  8'd127,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'd200, 8'd100, 8'd44,   1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'd127, 8'd1,   8'd128,  1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'd5,   8'd10,  8'hFB,   1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h80,  8'h01,  8'h7F,   1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'hFF,  8'h01,  8'h00,   1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'd10,  8'd5,   8'd5,    1'b1, 1'b0};
        tbl[7] = '{1'b1, 8'h00,  8'h00,  8'h00,   1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h80,  8'h80,  8'h00,   1'b1, 1'b1};
        tbl[9] = '{1'b1, 8'h7F,  8'hFF,  8'h80,   1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_state", 64'({busy, done, result, cout, ovf}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].m, tbl[i].x, tbl[i].y, {tbl[i].r, tbl[i].c, tbl[i].o});
        end

        for (int i = 0; i < 6; i++) begin
            logic         rm;
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            rm = 1'($urandom);
            rx = W'($urandom);
            ry = W'($urandom);
            run_op(rm, rx, ry, model(rm, rx, ry));
        end

        // Start pulses during RUN and DONE must be ignored
        wait_idle();
        d0    = done_cnt;
        mode  = 1'b0;
        a     = 8'd50;
        b     = 8'd60;
        start = 1'b1;
        sb.push_back({8'd110, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mode  = 1'b1;
        a     = 8'd3;
        b     = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("ignore_seq_done_seen", 64'(done), 64'(1));
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("ignore_done_count", 64'(done_cnt - d0), 64'(1));
        check("ignore_sb_empty", 64'(sb.size()), 64'(0));
        check("ignore_idle", 64'(busy), 64'(0));

        // Start held high: back-to-back launches every W+2 cycles
        mode  = 1'b0;
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back({8'd2, 1'b0, 1'b0});
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) idx.push_back(c);
            if (c == 2 * (W + 2)) start = 1'b0;
        end
        check("hold_done_count", 64'(idx.size()), 64'(3));
        if (idx.size() == 3) begin
            check("hold_first_done", 64'(idx[0]), 64'(W));
            check("hold_spacing_1", 64'(idx[1] - idx[0]), 64'(W + 2));
            check("hold_spacing_2", 64'(idx[2] - idx[1]), 64'(W + 2));
        end
        check("hold_sb_empty", 64'(sb.size()), 64'(0));

        // Asynchronous reset after the 4th bit step aborts the operation
        wait_idle();
        d0    = done_cnt;
        mode  = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        sb.push_back(model(1'b0, 8'h12, 8'h34));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", 64'({busy, done, result, cout, ovf}), 64'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        run_op(1'b1, 8'd200, 8'd55, model(1'b1, 8'd200, 8'd55));
        run_op(1'b0, 8'd100, 8'd27, {8'd127, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
